ysyx_22050598_ifu_fetch: RTL and testbench



---
 rtl/ysyx_22050598_ifu_fetch.sv | 137 +++++++++++++
 tb/tb_ysyx_22050598_ifu_fetch.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050598_ifu_fetch.sv
// Instruction fetch unit: holds the PC, issues one aligned 4-byte fetch at a time
// and hands the returned word, its PC and fault flags to decode over valid/ready.
module ysyx_22050598_ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        if_req_valid_o,
  output logic [63:0] if_req_addr_o,
  input  logic        if_req_ready_i,
  input  logic        if_rsp_valid_i,
  input  logic [31:0] if_rsp_data_i,
  input  logic        if_rsp_err_i,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic        id_valid_o,
  output logic [31:0] id_inst_o,
  output logic [63:0] id_pc_o,
  output logic [1:0]  id_fault_o,
  input  logic        id_ready_i
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] ipc_q, ipc_d;
  logic [1:0]  fault_q, fault_d;
  logic        misaligned;
  logic        req_hs;
  logic        id_hs;

  assign misaligned = (pc_q[1:0] != 2'b00);

  // A misaligned PC never reaches the bus; it is turned into a faulting nop instead.
  assign if_req_valid_o = (state_q == REQ) & ~drop_q & ~misaligned;
  assign if_req_addr_o  = pc_q;
  assign id_valid_o     = (state_q == HOLD);
  assign id_inst_o      = inst_q;
  assign id_pc_o        = ipc_q;
  assign id_fault_o     = fault_q;

  assign req_hs = if_req_valid_o & if_req_ready_i;
  assign id_hs  = id_valid_o & id_ready_i;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    fault_d = fault_q;

    if (redirect_valid_i) begin
      pc_d = redirect_pc_i;
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          // The bus took a request for the old PC; its response must be thrown away.
          if (req_hs) begin
            state_d = WAIT;
            drop_d  = 1'b1;
          end
        end
        WAIT: begin
          if (if_rsp_valid_i) begin
            state_d = REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        HOLD:    state_d = REQ;
        default: state_d = IDLE;
      endcase
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (misaligned) begin
            inst_d  = NOP_INST;
            ipc_d   = pc_q;
            fault_d = 2'b01;
            state_d = HOLD;
          end else if (req_hs) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (if_rsp_valid_i) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = REQ;
            end else begin
              inst_d  = if_rsp_data_i;
              ipc_d   = pc_q;
              fault_d = {if_rsp_err_i, 1'b0};
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (id_hs) begin
            pc_d    = pc_q + 64'd4;
            state_d = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= RESET_PC;
      fault_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22050598_ifu_fetch.sv
// Directed bench for the fetch unit: a transaction-level model predicts every cycle,
// and literal checks pin the key points of each scenario.
module tb_ysyx_22050598_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid_o;
  logic [63:0] if_req_addr_o;
  logic        if_req_ready_i;
  logic        if_rsp_valid_i;
  logic [31:0] if_rsp_data_i;
  logic        if_rsp_err_i;
  logic        redirect_valid_i;
  logic [63:0] redirect_pc_i;
  logic        id_valid_o;
  logic [31:0] id_inst_o;
  logic [63:0] id_pc_o;
  logic [1:0]  id_fault_o;
  logic        id_ready_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  ysyx_22050598_ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_req_valid_o   (if_req_valid_o),
    .if_req_addr_o    (if_req_addr_o),
    .if_req_ready_i   (if_req_ready_i),
    .if_rsp_valid_i   (if_rsp_valid_i),
    .if_rsp_data_i    (if_rsp_data_i),
    .if_rsp_err_i     (if_rsp_err_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .id_valid_o       (id_valid_o),
    .id_inst_o        (id_inst_o),
    .id_pc_o          (id_pc_o),
    .id_fault_o       (id_fault_o),
    .id_ready_i       (id_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Transaction-level model: fetch is either booting, waiting on a bus reply
  // (possibly stale), holding an instruction, or ready to request at m_pc.
  logic        m_boot, m_pending, m_stale, m_full;
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_inst;
  logic [1:0]  m_fault;
  logic        m_req;

  assign m_req = !m_boot && !m_pending && !m_full && (m_pc[1:0] == 2'b00);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_boot <= 1'b1; m_pending <= 1'b0; m_stale <= 1'b0; m_full <= 1'b0;
      m_pc <= RESET_PC; m_ipc <= RESET_PC; m_inst <= '0; m_fault <= '0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
      if (redirect_valid_i) m_pc <= redirect_pc_i;
    end else if (redirect_valid_i) begin
      m_pc   <= redirect_pc_i;
      m_full <= 1'b0;
      if (m_pending) begin
        if (if_rsp_valid_i) begin m_pending <= 1'b0; m_stale <= 1'b0; end
        else m_stale <= 1'b1;
      end else if (m_req && if_req_ready_i) begin
        m_pending <= 1'b1; m_stale <= 1'b1;
      end
    end else if (m_full) begin
      if (id_ready_i) begin m_full <= 1'b0; m_pc <= m_pc + 64'd4; end
    end else if (m_pending) begin
      if (if_rsp_valid_i) begin
        m_pending <= 1'b0;
        if (m_stale) m_stale <= 1'b0;
        else begin
          m_full <= 1'b1; m_inst <= if_rsp_data_i; m_ipc <= m_pc;
          m_fault <= {if_rsp_err_i, 1'b0};
        end
      end
    end else if (m_pc[1:0] != 2'b00) begin
      m_full <= 1'b1; m_inst <= 32'h0000_0013; m_ipc <= m_pc; m_fault <= 2'b01;
    end else if (if_req_ready_i) begin
      m_pending <= 1'b1;
    end
  end

  always @(negedge clk) begin
    check("m_req_valid", {63'd0, if_req_valid_o}, {63'd0, m_req});
    check("m_req_addr", if_req_addr_o, m_pc);
    check("m_id_valid", {63'd0, id_valid_o}, {63'd0, m_full});
    if (m_full) begin
      check("m_id_inst", {32'd0, id_inst_o}, {32'd0, m_inst});
      check("m_id_pc", id_pc_o, m_ipc);
      check("m_id_fault", {62'd0, id_fault_o}, {62'd0, m_fault});
    end
  end

  task automatic tick();
    @(negedge clk);
    redirect_valid_i = 1'b0;
    if_rsp_valid_i   = 1'b0;
    if_rsp_err_i     = 1'b0;
  endtask

  task automatic expect_req(input string name, input logic [63:0] addr);
    check({name, "_req_valid"}, {63'd0, if_req_valid_o}, 64'd1);
    check({name, "_req_addr"}, if_req_addr_o, addr);
  endtask

  task automatic expect_id(input string name, input logic [31:0] inst,
                           input logic [63:0] pc, input logic [1:0] fault);
    check({name, "_id_valid"}, {63'd0, id_valid_o}, 64'd1);
    check({name, "_id_inst"}, {32'd0, id_inst_o}, {32'd0, inst});
    check({name, "_id_pc"}, id_pc_o, pc);
    check({name, "_id_fault"}, {62'd0, id_fault_o}, {62'd0, fault});
  endtask

  // Accept one request now and answer it with a zero-wait response.
  task automatic fetch_one(input logic [31:0] data, input logic err);
    if_req_ready_i = 1'b1;
    tick();
    if_req_ready_i = 1'b0;
    if_rsp_valid_i = 1'b1;
    if_rsp_data_i  = data;
    if_rsp_err_i   = err;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; if_req_ready_i = 1'b0; if_rsp_valid_i = 1'b0; if_rsp_data_i = '0;
    if_rsp_err_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0;

    // Reset/boot
    repeat (3) begin
      @(negedge clk);
      check("rst_req_valid", {63'd0, if_req_valid_o}, 64'd0);
      check("rst_req_addr", if_req_addr_o, 64'h8000_0000);
    end
    check("rst_id_valid", {63'd0, id_valid_o}, 64'd0);
    check("rst_id_inst", {32'd0, id_inst_o}, 64'd0);
    check("rst_id_pc", id_pc_o, 64'h8000_0000);
    check("rst_id_fault", {62'd0, id_fault_o}, 64'd0);
    rst_n = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!if_req_valid_o && n < 8);
    check("boot_cycles_to_req", 64'(n), 64'd1);
    expect_req("boot", 64'h8000_0000);

    // Straight-line fetch with 5 cycles of decode backpressure
    fetch_one(32'h0010_0093, 1'b0);
    for (int i = 0; i < 5; i++) begin
      expect_id("bp", 32'h0010_0093, 64'h8000_0000, 2'b00);
      check("bp_req_valid", {63'd0, if_req_valid_o}, 64'd0);
      tick();
    end
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
    expect_req("seq", 64'h8000_0004);

    // Redirect in WAIT; response two cycles later is dropped
    if_req_ready_i = 1'b1;
    tick();
    if_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_1000;
    tick();
    check("rdw_addr_visible", if_req_addr_o, 64'h8000_1000);
    check("rdw_no_req_while_wait", {63'd0, if_req_valid_o}, 64'd0);
    tick();
    if_rsp_valid_i = 1'b1; if_rsp_data_i = 32'hdead_beef;
    tick();
    check("rdw_dropped", {63'd0, id_valid_o}, 64'd0);
    expect_req("rdw", 64'h8000_1000);
    fetch_one(32'h0030_0193, 1'b0);
    expect_id("rdw_next", 32'h0030_0193, 64'h8000_1000, 2'b00);
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
    expect_req("rdw_seq", 64'h8000_1004);

    // Misaligned redirect: faulting nop, no bus traffic
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_0002;
    tick();
    check("mis_no_req", {63'd0, if_req_valid_o}, 64'd0);
    if_req_ready_i = 1'b1;
    tick();
    if_req_ready_i = 1'b0;
    expect_id("mis", 32'h0000_0013, 64'h8000_0002, 2'b01);

    // Redirect in HOLD together with a decode handshake: PC comes from the redirect
    id_ready_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    id_ready_i = 1'b0;
    expect_req("hold_rd", 64'hFFFF_FFFF_FFFF_FFFC);

    // Access fault and PC wrap
    fetch_one(32'h1234_5678, 1'b1);
    expect_id("err", 32'h1234_5678, 64'hFFFF_FFFF_FFFF_FFFC, 2'b10);
    id_ready_i = 1'b1;
    tick();
    id_ready_i = 1'b0;
    expect_req("wrap", 64'h0);

    // Redirect coinciding with a request handshake: that request is stale
    if_req_ready_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_2000;
    tick();
    if_req_ready_i = 1'b0;
    if_rsp_valid_i = 1'b1; if_rsp_data_i = 32'h0bad_0001;
    tick();
    check("rdq_dropped", {63'd0, id_valid_o}, 64'd0);
    expect_req("rdq", 64'h8000_2000);

    // Redirect coinciding with the response in WAIT
    if_req_ready_i = 1'b1;
    tick();
    if_req_ready_i = 1'b0;
    if_rsp_valid_i = 1'b1; if_rsp_data_i = 32'h0bad_0002;
    redirect_valid_i = 1'b1; redirect_pc_i = 64'h8000_3000;
    tick();
    check("rdr_dropped", {63'd0, id_valid_o}, 64'd0);
    expect_req("rdr", 64'h8000_3000);

    // Response outside WAIT is ignored
    if_rsp_valid_i = 1'b1; if_rsp_data_i = 32'h0bad_0003;
    tick();
    check("stray_rsp", {63'd0, id_valid_o}, 64'd0);
    expect_req("stray", 64'h8000_3000);

    // Reset mid-operation with the reply arriving after release
    if_req_ready_i = 1'b1;
    tick();
    if_req_ready_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mrst_req_valid", {63'd0, if_req_valid_o}, 64'd0);
    check("mrst_req_addr", if_req_addr_o, RESET_PC);
    check("mrst_id_pc", id_pc_o, RESET_PC);
    tick();
    rst_n = 1'b1;
    if_rsp_valid_i = 1'b1; if_rsp_data_i = 32'h0bad_0004;
    tick();
    check("mrst_rsp_ignored", {63'd0, id_valid_o}, 64'd0);
    expect_req("mrst", RESET_PC);
    fetch_one(32'h0000_0517, 1'b0);
    expect_id("mrst_next", 32'h0000_0517, RESET_PC, 2'b00);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
